gem_manager: RTL and testbench

//  Owns all collectible diamonds in a level and shares one diamond sprite ROM between them.
//  - Per pixel: picks the uncollected gem covering (DrawX, DrawY) and drives the shared ROM address.
//  - Per frame: a sequential FSM tests the player box against every gem and marks collected gems.
//  - Sits between the VGA scan counters, the player logic and the diamond ROM/palette/colour mux.

---
 rtl/gem_manager.sv | 181 ++++++++++++++++++
 tb/tb_gem_manager.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gem_manager.sv
// gem_manager: owns the level's collectible diamonds and shares one sprite ROM.
//  - Pixel path: picks the lowest-index uncollected gem covering (DrawX, DrawY)
//    and drives the shared ROM address one cycle later.
//  - Collision FSM: once per frame, compares the latched player box against
//    one slot per cycle and marks hit gems collected.
// Optional feature: `define GEM_RESPAWN_EN to make collected gems respawn
// RESPAWN_FR frames after collection.
// Ports:
//  vga_clk, reset          pixel clock, async active-high reset
//  frame_start             1-cycle pulse at start of vertical blank
//  DrawX, DrawY            current scan pixel
//  player_x, player_y      player centre
//  cfg_we/idx/x/y          write a gem slot (valid=1, collected=0)
//  rom_address, gem_hit    registered sprite address / pixel-on-gem flag
//  collect_pulse           1-cycle pulse per collected gem
//  gem_count               gems collected since reset, saturating at 15
//  all_collected           every valid slot collected (0 if none valid)
//  busy                    collision scan in progress
module gem_manager #(
    parameter int unsigned NUM_GEMS    = 8,
    parameter int unsigned GEM_HALF    = 10,
    parameter int unsigned PLAYER_HALF = 12,
    parameter int unsigned RESPAWN_FR  = 120,
    localparam int unsigned IW         = $clog2(NUM_GEMS)
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic [9:0]    player_x,
    input  logic [9:0]    player_y,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [9:0]    cfg_x,
    input  logic [9:0]    cfg_y,
    output logic [8:0]    rom_address,
    output logic          gem_hit,
    output logic          collect_pulse,
    output logic [3:0]    gem_count,
    output logic          all_collected,
    output logic          busy
);

    localparam int unsigned REACH = GEM_HALF + PLAYER_HALF;
    localparam int unsigned SIDE  = 2 * GEM_HALF;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state, next_state;
    logic [IW-1:0]        idx;
    logic [9:0]           lpx, lpy;
    logic [9:0]           gx [NUM_GEMS];
    logic [9:0]           gy [NUM_GEMS];
    logic [NUM_GEMS-1:0]  valid, collected;

    logic                 pix_hit_c;
    logic [8:0]           pix_addr_c;
    logic [10:0]          pdx, pdy;
    logic                 scan_hit_c;
    logic [9:0]           cdx, cdy;

`ifdef GEM_RESPAWN_EN
    localparam int unsigned CW = $clog2(RESPAWN_FR + 1);
    logic [CW-1:0]        respawn_cnt [NUM_GEMS];
`endif

    // State register
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; frame_start outside IDLE is dropped
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (frame_start) next_state = SCAN;
            SCAN: if (idx == IW'(NUM_GEMS - 1)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pixel cover search; iterate high to low so the lowest index wins
    always_comb begin
        pix_hit_c  = 1'b0;
        pix_addr_c = '0;
        pdx        = '0;
        pdy        = '0;
        for (int i = NUM_GEMS - 1; i >= 0; i--) begin
            pdx = {1'b0, DrawX} + 11'(GEM_HALF) - {1'b0, gx[i]};
            pdy = {1'b0, DrawY} + 11'(GEM_HALF) - {1'b0, gy[i]};
            if (valid[i] && !collected[i]
                && ({1'b0, DrawX} + 11'(GEM_HALF) >= {1'b0, gx[i]})
                && ({1'b0, DrawX} < {1'b0, gx[i]} + 11'(GEM_HALF))
                && ({1'b0, DrawY} + 11'(GEM_HALF) >= {1'b0, gy[i]})
                && ({1'b0, DrawY} < {1'b0, gy[i]} + 11'(GEM_HALF))) begin
                pix_hit_c  = 1'b1;
                pix_addr_c = 9'(pdx) + 9'(pdy) * 9'(SIDE);
            end
        end
    end

    // Player-vs-slot test; a same-cycle config write to this slot wins
    always_comb begin
        cdx = (lpx >= gx[idx]) ? lpx - gx[idx] : gx[idx] - lpx;
        cdy = (lpy >= gy[idx]) ? lpy - gy[idx] : gy[idx] - lpy;
        scan_hit_c = (state == SCAN) && valid[idx] && !collected[idx]
                     && (cdx < 10'(REACH)) && (cdy < 10'(REACH))
                     && !(cfg_we && (cfg_idx == idx));
    end

    // Datapath, slot table and registered outputs
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            lpx           <= '0;
            lpy           <= '0;
            valid         <= '0;
            collected     <= '0;
            rom_address   <= '0;
            gem_hit       <= 1'b0;
            collect_pulse <= 1'b0;
            gem_count     <= '0;
            all_collected <= 1'b0;
            busy          <= 1'b0;
            for (int i = 0; i < NUM_GEMS; i++) begin
                gx[i] <= '0;
                gy[i] <= '0;
`ifdef GEM_RESPAWN_EN
                respawn_cnt[i] <= '0;
`endif
            end
        end else begin
            gem_hit       <= pix_hit_c;
            rom_address   <= pix_addr_c;
            collect_pulse <= scan_hit_c;
            busy          <= (next_state == SCAN);

            if (state == IDLE && frame_start) begin
                lpx <= player_x;
                lpy <= player_y;
                idx <= '0;
            end else if (state == SCAN) begin
                idx <= idx + IW'(1);
            end

            if (scan_hit_c) begin
                collected[idx] <= 1'b1;
                if (gem_count != 4'hF) gem_count <= gem_count + 4'd1;
`ifdef GEM_RESPAWN_EN
                respawn_cnt[idx] <= CW'(RESPAWN_FR);
`endif
            end

            if (state == DONE) begin
                all_collected <= (|valid) && ((valid & collected) == valid);
`ifdef GEM_RESPAWN_EN
                for (int i = 0; i < NUM_GEMS; i++) begin
                    if (respawn_cnt[i] != '0) begin
                        respawn_cnt[i] <= respawn_cnt[i] - CW'(1);
                        if (respawn_cnt[i] == CW'(1)) collected[i] <= 1'b0;
                    end
                end
`endif
            end

            if (cfg_we) begin
                gx[cfg_idx]        <= cfg_x;
                gy[cfg_idx]        <= cfg_y;
                valid[cfg_idx]     <= 1'b1;
                collected[cfg_idx] <= 1'b0;
`ifdef GEM_RESPAWN_EN
                respawn_cnt[cfg_idx] <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_gem_manager.sv
// Directed bench for gem_manager: pixel cover/address, collision scan timing,
// config priority, saturation and asynchronous reset.
module tb_gem_manager;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [9:0] DrawX, DrawY, player_x, player_y;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [9:0] cfg_x, cfg_y;
    logic [8:0] rom_address;
    logic       gem_hit, collect_pulse, all_collected, busy;
    logic [3:0] gem_count;

    int n_vec = 0;
    int n_err = 0;

    gem_manager dut (
        .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .player_x(player_x), .player_y(player_y),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .rom_address(rom_address), .gem_hit(gem_hit), .collect_pulse(collect_pulse),
        .gem_count(gem_count), .all_collected(all_collected), .busy(busy)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic cfg(input int i, input int x, input int y);
        cfg_we = 1'b1; cfg_idx = 3'(i); cfg_x = 10'(x); cfg_y = 10'(y);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pix(input string tag, input int x, input int y, input int hit, input int addr);
        DrawX = 10'(x); DrawY = 10'(y);
        step();
        check({tag, "_hit"}, int'(gem_hit), hit);
        check({tag, "_addr"}, int'(rom_address), addr);
    endtask

    // One frame: pulse frame_start, observe cycles 1..12; optional extra
    // frame_start at fs2 and config write at cfg_c (slot ci at cx,cy).
    task automatic run_frame(input int fs2, input int cfg_c, input int ci,
                             input int cx, input int cy,
                             output int pulses, output int first_pulse,
                             output int busy_n, output int busy_bad);
        pulses = 0; first_pulse = -1; busy_n = 0; busy_bad = 0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (busy) busy_n++;
            if (busy != (c >= 1 && c <= 8)) busy_bad++;
            if (collect_pulse) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c;
            end
            frame_start = (c == fs2);
            if (c == cfg_c) begin
                cfg_we = 1'b1; cfg_idx = 3'(ci); cfg_x = 10'(cx); cfg_y = 10'(cy);
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        frame_start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_hit"}, int'(gem_hit), 0);
        check({tag, "_addr"}, int'(rom_address), 0);
        check({tag, "_pulse"}, int'(collect_pulse), 0);
        check({tag, "_count"}, int'(gem_count), 0);
        check({tag, "_all"}, int'(all_collected), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    int p, fp, bn, bb;

    initial begin
        reset = 1'b1; frame_start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_x = '0; cfg_y = '0; DrawX = '0; DrawY = '0;
        player_x = 10'd100; player_y = 10'd100;
        step(); step();
        check_idle_outputs("reset");
        reset = 1'b0;
        step();

        // Pixel cover and sprite address
        cfg(0, 100, 100);
        pix("px_tl",   90,  90, 1, 0);
        pix("px_br",  109, 109, 1, 399);
        pix("px_right", 110, 100, 0, 0);
        pix("px_left",  89, 100, 0, 0);
        cfg(1, 105, 100);
        pix("px_overlap", 104, 100, 1, 214);

        // First frame: only gem0 near the player; duplicate frame_start ignored
        cfg(1, 500, 400);
        DrawX = 10'd0; DrawY = 10'd0;
        run_frame(3, -1, 0, 0, 0, p, fp, bn, bb);
        check("f1_pulses", p, 1);
        check("f1_first", fp, 2);
        check("f1_busy_n", bn, 8);
        check("f1_busy_win", bb, 0);
        check("f1_count", int'(gem_count), 1);
        pix("f1_px_gone", 100, 100, 0, 0);

        // Second frame: slot3 in reach, rewritten in its compare cycle
        cfg(3, 110, 100);
        run_frame(-1, 4, 3, 100, 100, p, fp, bn, bb);
        check("f2_pulses", p, 0);
        check("f2_count", int'(gem_count), 1);
        check("f2_all", int'(all_collected), 0);
        pix("f2_px_slot3", 100, 100, 1, 210);

        // Third frame: slot3 now collected at cycle 1+3+1
        run_frame(-1, -1, 0, 0, 0, p, fp, bn, bb);
        check("f3_pulses", p, 1);
        check("f3_first", fp, 5);
        check("f3_count", int'(gem_count), 2);
        check("f3_all", int'(all_collected), 0);

        // Collect all 8 slots
        for (int i = 0; i < 8; i++) cfg(i, 100 + i, 100);
        run_frame(-1, -1, 0, 0, 0, p, fp, bn, bb);
        check("f4_pulses", p, 8);
        check("f4_first", fp, 2);
        check("f4_count", int'(gem_count), 10);
        check("f4_all", int'(all_collected), 1);
        pix("f4_px_none", 100, 100, 0, 0);

        // Saturation at 15
        for (int i = 0; i < 8; i++) cfg(i, 100 + i, 100);
        run_frame(-1, -1, 0, 0, 0, p, fp, bn, bb);
        check("f5_pulses", p, 8);
        check("f5_count", int'(gem_count), 15);

        // Reset mid-scan
        cfg(5, 100, 100);
        DrawX = 10'd100; DrawY = 10'd100;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step(); step();
        #2 reset = 1'b1;
        #1 check_idle_outputs("midrst");
        step();
        reset = 1'b0;
        p = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (collect_pulse) p++;
        end
        check("midrst_pulses", p, 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_px", int'(gem_hit), 0);
        check("midrst_count", int'(gem_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
